layer0_input_packer: RTL

//  Streaming front end for logicnets layer 0. Takes signed readout samples one per

---
 rtl/layer0_input_packer.sv | 97 +++++++++
 1 files changed

// File: rtl/layer0_input_packer.sv
// Streaming input packer for logicnets layer 0.
// Quantizes signed samples (arithmetic shift + saturation) and packs NUM_FEAT
// of them into one vector held in a valid/ready output register.
module layer0_input_packer #(
  parameter int IN_W     = 16,
  parameter int Q_BITS   = 2,
  parameter int SHIFT    = 12,
  parameter int NUM_FEAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [IN_W-1:0]            s_data,
  input  logic                       s_first,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_FEAT*Q_BITS-1:0] m_data,
  output logic                       frame_err
);

  localparam int CNT_W = $clog2(NUM_FEAT);
  localparam int VEC_W = NUM_FEAT * Q_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEAT - 1);
  localparam int Q_MAX_I = (1 << (Q_BITS - 1)) - 1;
  localparam int Q_MIN_I = -(1 << (Q_BITS - 1));
  localparam logic signed [IN_W-1:0] Q_MAX = IN_W'(Q_MAX_I);
  localparam logic signed [IN_W-1:0] Q_MIN = IN_W'(Q_MIN_I);

  logic [CNT_W-1:0]        cnt;
  logic [VEC_W-1:0]        acc;
  logic [VEC_W-1:0]        acc_next;
  logic signed [IN_W-1:0]  shifted;
  logic [Q_BITS-1:0]       q;
  logic [CNT_W-1:0]        slot;
  logic                    accept;
  logic                    is_last;
  logic                    resync;

  // Quantize: sign-preserving shift, then clamp into the Q_BITS two's-complement range.
  always_comb begin
    shifted = $signed(s_data) >>> SHIFT;
    if (shifted > Q_MAX) begin
      q = Q_MAX[Q_BITS-1:0];
    end else if (shifted < Q_MIN) begin
      q = Q_MIN[Q_BITS-1:0];
    end else begin
      q = shifted[Q_BITS-1:0];
    end
  end

  // Handshake and slot selection; s_first only matters once a vector is partially filled.
  always_comb begin
    s_ready = (cnt != LAST) | ~m_valid | m_ready;
    accept  = s_valid & s_ready;
    slot    = s_first ? '0 : cnt;
    is_last = (slot == LAST);
    resync  = accept & s_first & (cnt != '0);
  end

  // Accumulator with the incoming feature dropped into its slot.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (slot == CNT_W'(k)) begin
        acc_next[k*Q_BITS +: Q_BITS] = q;
      end
    end
  end

  // Collect features, publish completed vectors, drain on m_ready; final accept wins over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync;
      if (m_valid & m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        acc <= acc_next;
        if (is_last) begin
          m_data  <= acc_next;
          m_valid <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= slot + CNT_W'(1);
        end
      end
    end
  end

endmodule
